i2c_init_sequencer: RTL and testbench

Table-driven sequencer that replays a host-loaded list of I2C register transactions into the `i2c_transmitter` command interface on each trigger. It is the parametrised successor to the fixed camera-init controller: it has configurable register address and data widths and table depth, a runtime-writable command table, inter-command delay entries, and an explicit end marker. It sits between the system control logic (trigger and table load) and `i2c_transmitter`.

---
 rtl/i2c_init_sequencer.sv | 139 +++++++++++++
 tb/tb_i2c_init_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C register-init sequencer: replays a host-loaded command table into i2c_transmitter.
// Optional DELAY opcode support is built when I2C_INIT_DELAY_EN is defined.
module i2c_init_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 64,
  parameter int DELAY_W = 16,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int ENTRY_W = 5 + ADDR_W + DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               trigger_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_addr_i,
  input  logic [ENTRY_W-1:0] cfg_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   entry_idx_o,
  output logic [ADDR_W-1:0]  reg_addr_o,
  output logic [DATA_W-1:0]  reg_data_o,
  output logic               rw_bit_o,
  output logic [1:0]         i2c_tx_phases_o,
  output logic               data_valid_o,
  input  logic               i2c_transmitter_ready
);

  if (DELAY_W > ADDR_W + DATA_W) begin : g_bad_delay_w
    $error("DELAY_W must not exceed ADDR_W + DATA_W");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_GUARD, S_WAIT, S_DELAY, S_NEXT, S_FINISH
  } state_t;

  localparam logic [1:0] OP_XFER  = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;

  state_t state, state_d;
  logic [IDX_W-1:0]   idx;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_q;

  logic [1:0]        ent_op, ent_ph;
  logic              ent_rw;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;

  assign ent_op   = rd_q[ENTRY_W-1 -: 2];
  assign ent_rw   = rd_q[ENTRY_W-3];
  assign ent_ph   = rd_q[ENTRY_W-4 -: 2];
  assign ent_addr = rd_q[DATA_W +: ADDR_W];
  assign ent_data = rd_q[DATA_W-1:0];

  // Table RAM: not reset; host writes land only while idle.
  always_ff @(posedge clock) begin
    if (cfg_we_i && state == S_IDLE) mem[cfg_addr_i] <= cfg_data_i;
    rd_q <= mem[idx];
  end

`ifdef I2C_INIT_DELAY_EN
  logic [DELAY_W-1:0] dly_cnt;
  logic [DELAY_W-1:0] dly_val;
  assign dly_val = rd_q[DELAY_W-1:0];

  always_ff @(posedge clock) begin
    if (reset)
      dly_cnt <= '0;
    else if (state == S_DECODE && ent_op == OP_DELAY)
      dly_cnt <= dly_val;
    else if (state == S_DELAY)
      dly_cnt <= dly_cnt - 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    busy_o       = (state != S_IDLE);
    done_o       = (state == S_FINISH);
    data_valid_o = (state == S_ISSUE);
    case (state)
      S_IDLE:   if (trigger_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (ent_op)
          OP_XFER:  state_d = S_ISSUE;
`ifdef I2C_INIT_DELAY_EN
          OP_DELAY: state_d = (dly_val == '0) ? S_NEXT : S_DELAY;
`else
          OP_DELAY: state_d = S_NEXT;
`endif
          default:  state_d = S_FINISH;
        endcase
      end
      S_ISSUE:  if (i2c_transmitter_ready) state_d = S_GUARD;
      // Transmitter drops ready one cycle after accept; skip that stale cycle.
      S_GUARD:  state_d = S_WAIT;
      S_WAIT:   if (i2c_transmitter_ready) state_d = S_NEXT;
`ifdef I2C_INIT_DELAY_EN
      S_DELAY:  if (dly_cnt == DELAY_W'(1)) state_d = S_NEXT;
`else
      S_DELAY:  state_d = S_NEXT;
`endif
      S_NEXT:   state_d = (idx == IDX_W'(DEPTH-1)) ? S_FINISH : S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx             <= '0;
      reg_addr_o      <= '0;
      reg_data_o      <= '0;
      rw_bit_o        <= 1'b0;
      i2c_tx_phases_o <= 2'b00;
    end else begin
      if (state == S_IDLE && trigger_i)
        idx <= '0;
      else if (state == S_NEXT && idx != IDX_W'(DEPTH-1))
        idx <= idx + 1'b1;
      // Command fields are captured on the way into ISSUE and held afterwards.
      if (state == S_DECODE && ent_op == OP_XFER) begin
        reg_addr_o      <= ent_addr;
        reg_data_o      <= ent_data;
        rw_bit_o        <= ent_rw;
        i2c_tx_phases_o <= ent_ph;
      end
    end
  end

  assign entry_idx_o = idx;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Scoreboard bench for i2c_init_sequencer: directed tables, transmitter model, decoupled monitor.
module tb_i2c_init_sequencer;
  localparam int ADDR_W = 16, DATA_W = 8, DEPTH = 64, IDX_W = 6, ENTRY_W = 29;
`ifdef I2C_INIT_DELAY_EN
  localparam int DLY_EXTRA = 100;
`else
  localparam int DLY_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, trigger = 1'b0, cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [ENTRY_W-1:0] cfg_data = '0;
  logic busy_o, done_o, rw_bit_o, data_valid_o;
  logic [IDX_W-1:0] entry_idx_o;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_data_o;
  logic [1:0] ph_o;
  logic rdy_int = 1'b1, hold = 1'b0, ready;
  int lat = 0, bcnt = 0, cyc = 0;

  assign ready = rdy_int & ~hold;
  always #5 clk = ~clk;

  i2c_init_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(16)) dut (
    .clock(clk), .reset(reset), .trigger_i(trigger), .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .busy_o(busy_o), .done_o(done_o),
    .entry_idx_o(entry_idx_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
    .rw_bit_o(rw_bit_o), .i2c_tx_phases_o(ph_o), .data_valid_o(data_valid_o),
    .i2c_transmitter_ready(ready));

  typedef struct packed {
    logic [IDX_W-1:0] idx; logic rw; logic [1:0] ph; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;
  } cmd_t;

  cmd_t exp_q[$];
  int acc_cyc[$];
  int checks = 0, errors = 0, done_cnt = 0, dv_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transmitter: ready drops after each accept and stays low for lat+1 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      rdy_int <= 1'b1; bcnt <= 0;
    end else if (data_valid_o && ready) begin
      rdy_int <= 1'b0; bcnt <= lat;
    end else if (!rdy_int) begin
      if (bcnt == 0) rdy_int <= 1'b1;
      else bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done_o) done_cnt++;
      if (data_valid_o && !ready && !hold) dv_stall++;
      if (data_valid_o && ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected got idx %0d addr %0h want none", entry_idx_o, reg_addr_o);
        end else begin
          cmd_t e, g;
          e = exp_q.pop_front();
          g = '{idx: entry_idx_o, rw: rw_bit_o, ph: ph_o, a: reg_addr_o, d: reg_data_o};
          chk("cmd", 64'(g), 64'(e));
        end
      end
    end
  end

  function automatic logic [ENTRY_W-1:0] mk(input logic [1:0] op, input logic rw,
      input logic [1:0] ph, input logic [15:0] a, input logic [7:0] d);
    return {op, rw, ph, a, d};
  endfunction

  task automatic step(); @(negedge clk); #1; endtask

  task automatic load(input int i, input logic [ENTRY_W-1:0] e);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = IDX_W'(i); cfg_data = e;
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  task automatic push(input int i, input logic rw, input logic [1:0] ph,
      input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{idx: IDX_W'(i), rw: rw, ph: ph, a: a, d: d});
  endtask

  task automatic trig();
    @(negedge clk); trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    step();
    chk("busy_after_done", 64'(busy_o), 64'd0);
    repeat (4) step();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_basic();
    load(0, mk(2'b00, 1'b0, 2'b11, 16'h3008, 8'h82));
    load(1, mk(2'b00, 1'b0, 2'b11, 16'h3103, 8'h03));
    load(2, mk(2'b10, 1'b0, 2'b00, 16'h0000, 8'h00));
  endtask

  task automatic push_basic();
    push(0, 1'b0, 2'b11, 16'h3008, 8'h82);
    push(1, 1'b0, 2'b11, 16'h3103, 8'h03);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_dv", 64'(data_valid_o), 0);
    chk("rst_idx", 64'(entry_idx_o), 0);
    chk("rst_fields", 64'({reg_addr_o, reg_data_o, rw_bit_o, ph_o}), 0);
    reset = 1'b0;

    // Two transfers then END, ready always high; check trigger-to-valid latency.
    load_basic(); push_basic(); acc_cyc.delete();
    @(negedge clk); trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    step(); chk("t1_busy", 64'(busy_o), 1); chk("t1_dv_fetch", 64'(data_valid_o), 0);
    step(); chk("t1_dv_decode", 64'(data_valid_o), 0);
    step(); chk("t1_dv_issue", 64'(data_valid_o), 1);
    wait_done(500);
    chk("t1_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);

    // Slow transmitter: 41 low-ready cycles after each accept.
    lat = 40; push_basic(); acc_cyc.delete();
    trig(); wait_done(1000);
    chk("t2_accepts", 64'(acc_cyc.size()), 64'd2);
    chk("t2_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd46);
    chk("t2_no_stall_valid", 64'(dv_stall), 64'd0);

    // DELAY 100 between two transfers.
    lat = 0;
    load(0, mk(2'b00, 1'b1, 2'b01, 16'h1111, 8'h22));
    load(1, mk(2'b01, 1'b0, 2'b00, 16'h0000, 8'd100));
    load(2, mk(2'b00, 1'b0, 2'b10, 16'h3333, 8'h44));
    load(3, mk(2'b11, 1'b0, 2'b00, 16'h0000, 8'h00));
    push(0, 1'b1, 2'b01, 16'h1111, 8'h22);
    push(2, 1'b0, 2'b10, 16'h3333, 8'h44);
    acc_cyc.delete();
    trig(); wait_done(1000);
    chk("t3_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(9 + DLY_EXTRA));

    // Full table of XFERs with no END terminates after the last index.
    for (int i = 0; i < DEPTH; i++) begin
      load(i, mk(2'b00, i[0], i[1:0], 16'(16'h0100 + i * 3), 8'(i ^ 8'h5A)));
      push(i, i[0], i[1:0], 16'(16'h0100 + i * 3), 8'(i ^ 8'h5A));
    end
    acc_cyc.delete();
    trig(); wait_done(2000);
    chk("t4_accepts", 64'(acc_cyc.size()), 64'(DEPTH));
    chk("t4_last_idx", 64'(entry_idx_o), 64'(DEPTH - 1));

    // Trigger and table write mid-playback are ignored.
    lat = 40; load_basic(); push_basic(); acc_cyc.delete();
    trig();
    n = 0;
    while (acc_cyc.size() == 0 && n < 100) begin step(); n++; end
    chk("t5_first_accept", 64'(acc_cyc.size()), 64'd1);
    trigger = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd1;
    cfg_data = mk(2'b00, 1'b1, 2'b00, 16'hDEAD, 8'hBE);
    @(posedge clk); #1 trigger = 1'b0; cfg_we = 1'b0;
    wait_done(1000);
    push_basic(); trig(); wait_done(1000);

    // Reset while holding in ISSUE, then replay from entry 0.
    lat = 0; hold = 1'b1;
    trig();
    n = 0;
    while (!data_valid_o && n < 10) begin step(); n++; end
    chk("t6_in_issue", 64'(data_valid_o), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_dv", 64'(data_valid_o), 0);
    chk("t6_rst_busy", 64'(busy_o), 0);
    chk("t6_rst_idx", 64'(entry_idx_o), 0);
    reset = 1'b0; hold = 1'b0;
    push_basic(); trig(); wait_done(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
